sram_req_ctrl: RTL and testbench
================================

SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16, word width of SRAM data and response data.
REQ-002 Parameter ADDR_WIDTH, default 4, width of SRAM read and write addresses.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 wr_valid  input  1  write request valid.
REQ-006 wr_ready  output  1  write request accepted this cycle.
REQ-007 wr_addr  input  ADDR_WIDTH  write address.
REQ-008 wr_data  input  DATA_WIDTH  write data.
REQ-009 rd_valid  input  1  read request valid.
REQ-010 rd_ready  output  1  read request accepted this cycle.
REQ-011 rd_addr  input  ADDR_WIDTH  read address.
REQ-012 rsp_valid  output  1  read response valid.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_data  output  DATA_WIDTH  read response data.
REQ-015 sram_cs, sram_we  output  1 each  SRAM chip select and write enable.
REQ-016 sram_r_addr, sram_w_addr  output  ADDR_WIDTH each  SRAM read and write addresses.
REQ-017 sram_din  output  DATA_WIDTH  SRAM write data.
REQ-018 sram_dout  input  DATA_WIDTH  SRAM registered read data, valid in the cycle after a read is issued.
REQ-019 idle  output  1  no read in flight and response FIFO empty.

Function
REQ-020 A transfer SHALL occur on a channel when valid and ready are both high at a rising edge; ready SHALL NOT depend on rsp_ready.
REQ-021 At most one SRAM operation SHALL be issued per cycle: either write grant (wg) or read grant (rg), never both.
REQ-022 Read eligibility SHALL be rd_el = (fifo_count + inflight) < 3, with inflight in {0,1} and response FIFO depth 3.
REQ-023 If only one of wr_valid or (rd_valid and rd_el) is high, that request SHALL be granted.
REQ-024 If both are high, the grant SHALL go to the channel whose priority flag is set; the flag SHALL toggle only on contended grants and reset to write priority.
REQ-025 wr_ready = wg and rd_ready = rg, both combinational.
REQ-026 sram_cs = wg or rg; sram_we = wg; sram_w_addr = wr_addr; sram_din = wr_data; sram_r_addr = rd_addr; all combinational.
REQ-027 inflight SHALL be set at the edge ending a cycle with rg and cleared at the next edge unless rg is high again.
REQ-028 In a cycle with inflight=1, sram_dout SHALL be pushed into the response FIFO at the ending edge; sram_dout SHALL be ignored when inflight=0.
REQ-029 Read latency: handshake in cycle N gives rsp_valid high with that data in cycle N+2 when the FIFO was empty.
REQ-030 rsp_valid = (fifo_count != 0); rsp_data = FIFO head, registered; pop occurs on rsp_valid and rsp_ready.
REQ-031 Simultaneous push and pop SHALL leave fifo_count unchanged; push when full is impossible by REQ-022.
REQ-032 Responses SHALL return in read-issue order; no ordering is guaranteed between the read and write channels beyond issue order.
REQ-033 With rsp_ready held high, sustained reads SHALL achieve one accepted read per cycle.
REQ-034 idle = (inflight == 0) and (fifo_count == 0).

Reset
REQ-035 On rstn low, inflight, fifo_count, FIFO pointers and the priority flag SHALL clear immediately: rsp_valid=0, idle=1, priority=write.
REQ-036 During reset, wr_ready, rd_ready, sram_cs and sram_we SHALL be 0.
REQ-037 A read in flight when reset asserts SHALL be discarded and SHALL produce no response after reset release.

Verification
REQ-038 Write addr 3 data 0xA5A5, then read addr 3 with rsp_ready=1 -> rsp_valid two cycles after read handshake, rsp_data=0xA5A5.
REQ-039 wr_valid and rd_valid held high for 4 cycles from reset -> grants alternate W,R,W,R; sram_we pattern 1,0,1,0.
REQ-040 rsp_ready=0, rd_valid high -> exactly 3 reads accepted, then rd_ready=0; raise rsp_ready -> 3 responses in issue order, then reads resume.
REQ-041 Back-to-back reads of addr 0..7 with rsp_ready=1 -> rd_ready high every cycle, 8 consecutive rsp_valid cycles, data in address order.
REQ-042 Assert rstn low the cycle after a read handshake -> rsp_valid=0 and idle=1 during reset; no response after release.
REQ-043 wr_valid high and rd_el=0 (FIFO full plus in-flight) -> write granted every cycle regardless of priority flag.

Source files
------------

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: arbitrates a write channel and a read channel onto a
// single-port style SRAM interface (one operation per cycle) and returns read
// data through a 3-entry response FIFO.
//
// Handshake rule for every channel (wr, rd, rsp): a transfer happens at a
// rising edge where valid and ready are both high. Ready never depends on the
// downstream rsp_ready, and valid is not expected to depend on ready.
//
// Read data comes back from the SRAM one cycle after the read is issued. The
// in-flight flag marks that cycle so the data can be captured into the FIFO.
// Reads are only granted while FIFO entries plus in-flight reads stay below the
// FIFO depth, which guarantees that a returning read always has a free slot.
module sram_req_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_r_addr,
  output logic [ADDR_WIDTH-1:0] sram_w_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  idle
);

  localparam int FIFO_DEPTH = 3;

  logic                  inflight;
  logic [1:0]            fifo_count;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic                  pri_rd;      // 1: read wins the next contended cycle

  logic [2:0]            occupancy;
  logic                  rd_el;
  logic                  rd_req;
  logic                  contended;
  logic                  wg;
  logic                  rg;
  logic                  push;
  logic                  pop;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Grant selection: single requester wins outright, contention uses the flag.
  // Grants are forced low while reset is asserted.
  always_comb begin
    wg        = 1'b0;
    rg        = 1'b0;
    occupancy = {1'b0, fifo_count} + {2'b00, inflight};
    rd_el     = (occupancy < 3'(FIFO_DEPTH));
    rd_req    = rd_valid & rd_el;
    contended = rstn & wr_valid & rd_req;
    if (rstn) begin
      if (wr_valid && rd_req) begin
        rg = pri_rd;
        wg = ~pri_rd;
      end else begin
        wg = wr_valid;
        rg = rd_req;
      end
    end
  end

  assign wr_ready    = wg;
  assign rd_ready    = rg;
  assign sram_cs     = wg | rg;
  assign sram_we     = wg;
  assign sram_w_addr = wr_addr;
  assign sram_din    = wr_data;
  assign sram_r_addr = rd_addr;

  assign push      = inflight;
  assign rsp_valid = (fifo_count != 2'd0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = fifo_mem[rd_ptr];
  assign idle      = ~inflight & (fifo_count == 2'd0);

  // Priority flag flips only when both channels competed for the grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pri_rd <= 1'b0;
    end else if (contended) begin
      pri_rd <= ~pri_rd;
    end
  end

  // In-flight flag: marks the cycle in which sram_dout carries read data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight <= 1'b0;
    end else begin
      inflight <= rg;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keeps the count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_count <= 2'd0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage: captures returning SRAM read data.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= sram_dout;
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: SRAM behavioural memory, transaction-level model
// (pending-read queue with visibility cycles), per-cycle compare, directed
// scenarios with literal expectations, then randomized traffic.
module tb_sram_req_ctrl;

  localparam int DW = 16;
  localparam int AW = 4;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr  = '0;
  logic [DW-1:0] wr_data  = '0;
  logic          rd_valid = 1'b0;
  logic          rd_ready;
  logic [AW-1:0] rd_addr  = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          sram_cs;
  logic          sram_we;
  logic [AW-1:0] sram_r_addr;
  logic [AW-1:0] sram_w_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout = '0;
  logic          idle;

  sram_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_addr     (rd_addr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .sram_cs     (sram_cs),
    .sram_we     (sram_we),
    .sram_r_addr (sram_r_addr),
    .sram_w_addr (sram_w_addr),
    .sram_din    (sram_din),
    .sram_dout   (sram_dout),
    .idle        (idle)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return 16'h1000 | DW'(a);
  endfunction

  // ---------------- SRAM behavioural memory ----------------
  logic [DW-1:0] smem [16];
  logic [15:0]   s_written = '0;
  always @(posedge clk) begin
    if (sram_cs && sram_we) begin
      smem[sram_w_addr]      <= sram_din;
      s_written[sram_w_addr] <= 1'b1;
    end else if (sram_cs) begin
      sram_dout <= s_written[sram_r_addr] ? smem[sram_r_addr] : init_val(sram_r_addr);
    end
  end

  // ---------------- reference model / scoreboard ----------------
  // exp_q holds every read issued and not yet consumed (in flight or queued);
  // vis_q holds the cycle from which that response may be presented.
  logic [DW-1:0] exp_q[$];
  int            vis_q[$];
  logic [DW-1:0] mmem [16];
  logic [15:0]   m_written = '0;
  logic          pri_wr = 1'b1;
  int            cyc = 0;

  function automatic void model_grants(output logic gw, output logic gr);
    logic rr;
    rr = rd_valid && (exp_q.size() < 3);
    if (wr_valid && rr) begin
      gw = pri_wr;
      gr = !pri_wr;
    end else begin
      gw = wr_valid;
      gr = rr;
    end
  endfunction

  always @(posedge clk) begin : model_upd
    logic gw, gr, cont;
    if (!rstn) begin
      exp_q.delete();
      vis_q.delete();
      pri_wr <= 1'b1;
    end else begin
      model_grants(gw, gr);
      cont = wr_valid && rd_valid && (exp_q.size() < 3);
      if (exp_q.size() > 0 && vis_q[0] <= cyc && rsp_ready) begin
        void'(exp_q.pop_front());
        void'(vis_q.pop_front());
      end
      if (gr) begin
        exp_q.push_back(m_written[rd_addr] ? mmem[rd_addr] : init_val(rd_addr));
        vis_q.push_back(cyc + 2);
      end
      if (gw) begin
        mmem[wr_addr]      <= wr_data;
        m_written[wr_addr] <= 1'b1;
      end
      if (cont) pri_wr <= !pri_wr;
    end
    cyc <= cyc + 1;
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin : cmp
    logic gw, gr, ev;
    if (!rstn) begin
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_ready", rd_ready, 0);
      chk("rst_sram_cs", sram_cs, 0);
      chk("rst_sram_we", sram_we, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_idle", idle, 1);
    end else begin
      model_grants(gw, gr);
      ev = (exp_q.size() > 0) && (vis_q[0] <= cyc);
      chk("wr_ready", wr_ready, gw);
      chk("rd_ready", rd_ready, gr);
      chk("sram_cs", sram_cs, gw | gr);
      chk("sram_we", sram_we, gw);
      chk("rsp_valid", rsp_valid, ev);
      chk("idle", idle, exp_q.size() == 0);
      if (ev) chk("rsp_data", rsp_data, exp_q[0]);
      if (gw) begin
        chk("sram_w_addr", sram_w_addr, wr_addr);
        chk("sram_din", sram_din, wr_data);
      end
      if (gr) chk("sram_r_addr", sram_r_addr, rd_addr);
    end
  end

  // ---------------- driver tasks ----------------
  logic          s_wr_ready, s_rd_ready, s_we, s_rsp_valid, s_idle;
  logic [DW-1:0] s_rsp_data;

  task automatic step();
    @(negedge clk);
    s_wr_ready  = wr_ready;
    s_rd_ready  = rd_ready;
    s_we        = sram_we;
    s_rsp_valid = rsp_valid;
    s_rsp_data  = rsp_data;
    s_idle      = idle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic clear_inputs();
    wr_valid = 1'b0;
    rd_valid = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    clear_inputs();
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_idle) break;
    end
    chk("drain_idle", s_idle, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int acc, resumed, a, nvalid, first, last, wcnt, rcnt, k;
    logic [3:0] we_seq, rd_seq;
    logic [DW-1:0] got[$];

    do_reset();

    // Write then read back with fixed two-cycle latency.
    rsp_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 16'hA5A5;
    step();
    chk("wr_handshake", s_wr_ready, 1);
    wr_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 4'd3;
    step();
    chk("rd_handshake", s_rd_ready, 1);
    rd_valid = 1'b0;
    step();
    chk("lat_n1_valid", s_rsp_valid, 0);
    step();
    chk("lat_n2_valid", s_rsp_valid, 1);
    chk("lat_n2_data", s_rsp_data, 16'hA5A5);
    drain();

    // Contention from reset alternates W,R,W,R.
    do_reset();
    we_seq = '0; rd_seq = '0;
    wr_valid = 1'b1; wr_addr = 4'd12; rd_valid = 1'b1; rd_addr = 4'd5;
    for (int i = 0; i < 4; i++) begin
      wr_data = 16'($urandom);
      step();
      we_seq = {we_seq[2:0], s_we};
      rd_seq = {rd_seq[2:0], s_rd_ready};
    end
    chk("alt_we_seq", 32'(we_seq), 32'hA);
    chk("alt_rd_seq", 32'(rd_seq), 32'h5);
    drain();

    // Backpressure: three reads fit, then reads stall until responses drain.
    rsp_ready = 1'b0; rd_valid = 1'b1; a = 8; acc = 0;
    for (int i = 0; i < 6; i++) begin
      rd_addr = AW'(a);
      step();
      if (s_rd_ready) begin acc++; a++; end
    end
    chk("bp_accepted", acc, 3);
    chk("bp_stalled", s_rd_ready, 0);
    rsp_ready = 1'b1; resumed = 0;
    got.delete();
    for (int i = 0; i < 10; i++) begin
      rd_addr = AW'(a);
      step();
      if (s_rsp_valid) got.push_back(s_rsp_data);
      if (s_rd_ready) begin resumed++; a++; end
    end
    if (got.size() >= 3) begin
      chk("bp_rsp0", got[0], 16'h1008);
      chk("bp_rsp1", got[1], 16'h1009);
      chk("bp_rsp2", got[2], 16'h100A);
    end else begin
      chk("bp_rsp_count", got.size(), 3);
    end
    chk("bp_resumed", resumed > 0, 1);
    drain();

    // Back-to-back reads of addresses 0..7.
    rsp_ready = 1'b1; acc = 0; nvalid = 0; first = -1; last = -1;
    got.delete();
    for (k = 0; k < 20; k++) begin
      rd_valid = (k < 8);
      rd_addr  = AW'(k);
      step();
      if (k < 8 && s_rd_ready) acc++;
      if (s_rsp_valid) begin
        nvalid++;
        if (first < 0) first = k;
        last = k;
        got.push_back(s_rsp_data);
      end
    end
    chk("b2b_rd_ready", acc, 8);
    chk("b2b_nvalid", nvalid, 8);
    chk("b2b_contiguous", last - first + 1, 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk("b2b_data", got[i], (i == 3) ? 16'hA5A5 : (16'h1000 + 16'(i)));
    drain();

    // FIFO full plus in-flight: writes win every cycle.
    rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 4'd1;
    for (int i = 0; i < 5; i++) step();
    wr_valid = 1'b1; wr_addr = 4'd13; wcnt = 0; rcnt = 0;
    for (int i = 0; i < 4; i++) begin
      wr_data = 16'($urandom);
      step();
      if (s_wr_ready) wcnt++;
      if (s_rd_ready) rcnt++;
    end
    chk("full_wr_grants", wcnt, 4);
    chk("full_rd_grants", rcnt, 0);
    drain();

    // Reset right after a read handshake discards the read.
    rsp_ready = 1'b1; rd_valid = 1'b1; rd_addr = 4'd2;
    step();
    chk("rstmid_handshake", s_rd_ready, 1);
    rd_valid = 1'b0;
    rstn = 1'b0;
    step();
    chk("rstmid_valid", s_rsp_valid, 0);
    chk("rstmid_idle", s_idle, 1);
    step();
    rstn = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_rsp_valid) nvalid++;
    end
    chk("rstmid_no_rsp", nvalid, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      wr_valid  = ($urandom_range(0, 2) == 0);
      wr_addr   = AW'($urandom_range(0, 15));
      wr_data   = 16'($urandom);
      rd_valid  = ($urandom_range(0, 1) == 1);
      rd_addr   = AW'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) do_reset();
      else step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
